// File: rtl/aa_stream_filter.sv
// aa_stream_filter: streaming 3x3 anti-aliasing filter over a raster pixel stream.
// Each channel is filtered independently with the kernel
//   out = (4*C + 2*(N+S+E+W) + (NW+NE+SW+SE) + 8) >> 4
// and the frame edges are clamped, so border pixels see the nearest in-frame pixel as their neighbour.
// Two full-line buffers hold rows y-2 and y-1. Three 2-deep column windows hold the previously
// accepted columns of the top, middle and bottom rows.
//
// Optional feature: define AA_BYPASS_EN to add the 'bypass' input. When bypass is 1 at the
// moment an output is produced, m_data carries the unfiltered centre pixel.
//
// Ports:
//   clk, rst_n         pixel clock, asynchronous active-low reset
//   s_valid/s_ready    input handshake; s_sof marks pixel (0,0); s_data is the input pixel
//   m_valid/m_ready    output handshake; m_sof marks (0,0), m_eol marks the last column; m_data is the filtered pixel
//   frame_err          one-cycle pulse when s_sof arrives in the middle of a frame
//   bypass             (AA_BYPASS_EN only) passes the centre pixel through unfiltered
module aa_stream_filter #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned CHANNELS = 3,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480
) (
  input  logic                         clk,
  input  logic                         rst_n,
`ifdef AA_BYPASS_EN
  input  logic                         bypass,
`endif
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic                         s_sof,
  input  logic [CHANNELS*DATA_W-1:0]   s_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic                         m_sof,
  output logic                         m_eol,
  output logic [CHANNELS*DATA_W-1:0]   m_data,
  output logic                         frame_err
);

  localparam int unsigned PW = CHANNELS * DATA_W;
  localparam int unsigned XW = $clog2(H_ACTIVE);
  localparam int unsigned YW = $clog2(V_ACTIVE);
  localparam int unsigned SW = DATA_W + 4;
  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

  typedef enum logic [2:0] {S_IDLE, S_PRIME, S_RUN, S_EOL, S_FLUSH} state_t;

  state_t          state;
  logic [XW-1:0]   x;
  logic [YW-1:0]   y;
  logic            rst_done;

  // lb0 holds row y-2, lb1 holds row y-1 (both hold row 0 after priming, which clamps the top edge)
  logic [PW-1:0]   lb0 [H_ACTIVE];
  logic [PW-1:0]   lb1 [H_ACTIVE];

  // Column windows: *1 is the last accepted column, *2 the one before it
  logic [PW-1:0]   tp1, tp2, mp1, mp2, bp1, bp2;

  logic            can_load;
  logic            accept;
  logic            restart;
  logic            load;
  logic            out_sof;
  logic            out_eol;
  logic            use_bypass;
  logic [XW-1:0]   wx;
  logic [XW-1:0]   fx_l;
  logic [XW-1:0]   fx_r;
  logic [PW-1:0]   n_tl, n_tc, n_tr, n_ml, n_mc, n_mr, n_bl, n_bc, n_br;
  logic [SW-1:0]   acc;
  logic [PW-1:0]   filt;
  logic [PW-1:0]   out_data;

  function automatic logic [SW-1:0] chan(input logic [PW-1:0] p, input int unsigned c);
    return SW'(p[c*DATA_W +: DATA_W]);
  endfunction

`ifdef AA_BYPASS_EN
  assign use_bypass = bypass;
`else
  assign use_bypass = 1'b0;
`endif

  // Handshake and event decode
  always_comb begin
    can_load = !m_valid || m_ready;
    s_ready  = 1'b0;
    case (state)
      S_IDLE:  s_ready = rst_done;
      S_PRIME: s_ready = 1'b1;
      S_RUN:   s_ready = can_load;
      default: s_ready = 1'b0;
    endcase
    accept  = s_valid && s_ready;
    restart = accept && s_sof && (state != S_IDLE);
    load    = !restart &&
              ((state == S_RUN && accept && x != '0) ||
               ((state == S_EOL || state == S_FLUSH) && can_load));
    out_sof = (state == S_RUN) && (x == XW'(1)) && (y == YW'(1));
    out_eol = (state == S_EOL) || (state == S_FLUSH && x == X_LAST);
    wx      = restart ? '0 : x;
  end

  // 3x3 neighbourhood selection for the pixel being produced this cycle
  always_comb begin
    fx_l = (x == '0)    ? x : x - XW'(1);
    fx_r = (x == X_LAST) ? x : x + XW'(1);
    // End-of-line output: right column clamps onto the last column
    n_tl = tp2; n_tc = tp1; n_tr = tp1;
    n_ml = mp2; n_mc = mp1; n_mr = mp1;
    n_bl = bp2; n_bc = bp1; n_br = bp1;
    case (state)
      S_RUN: begin
        // Output column is x-1; at x==1 the left column clamps onto column 0
        n_tl = (x == XW'(1)) ? tp1 : tp2; n_tc = tp1; n_tr = lb0[x];
        n_ml = (x == XW'(1)) ? mp1 : mp2; n_mc = mp1; n_mr = lb1[x];
        n_bl = (x == XW'(1)) ? bp1 : bp2; n_bc = bp1; n_br = s_data;
      end
      S_FLUSH: begin
        // Last row: south neighbours replicate the row itself
        n_tl = lb0[fx_l]; n_tc = lb0[x]; n_tr = lb0[fx_r];
        n_ml = lb1[fx_l]; n_mc = lb1[x]; n_mr = lb1[fx_r];
        n_bl = lb1[fx_l]; n_bc = lb1[x]; n_br = lb1[fx_r];
      end
      default: ;
    endcase
  end

  // Per-channel kernel; the 4-bit headroom holds 16*max+8 without overflow
  always_comb begin
    acc  = '0;
    filt = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      acc = (chan(n_mc, c) << 2)
          + ((chan(n_tc, c) + chan(n_bc, c) + chan(n_ml, c) + chan(n_mr, c)) << 1)
          + chan(n_tl, c) + chan(n_tr, c) + chan(n_bl, c) + chan(n_br, c)
          + SW'(8);
      filt[c*DATA_W +: DATA_W] = acc[SW-1:4];
    end
    out_data = use_bypass ? n_mc : filt;
  end

  // Line buffers: priming writes row 0 into both, so row 1 sees row 0 as its north neighbour
  always_ff @(posedge clk) begin
    if (accept) begin
      if (state == S_RUN && !restart) begin
        lb0[x] <= lb1[x];
        lb1[x] <= s_data;
      end else begin
        lb0[wx] <= s_data;
        lb1[wx] <= s_data;
      end
    end
  end

  // Control FSM, column windows and output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      x         <= '0;
      y         <= '0;
      rst_done  <= 1'b0;
      m_valid   <= 1'b0;
      m_sof     <= 1'b0;
      m_eol     <= 1'b0;
      m_data    <= '0;
      frame_err <= 1'b0;
      tp1 <= '0; tp2 <= '0;
      mp1 <= '0; mp2 <= '0;
      bp1 <= '0; bp2 <= '0;
    end else begin
      rst_done  <= 1'b1;
      frame_err <= restart;

      if (restart) begin
        m_valid <= 1'b0;
      end else if (load) begin
        m_valid <= 1'b1;
        m_data  <= out_data;
        m_sof   <= out_sof;
        m_eol   <= out_eol;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end

      if (restart || (state == S_IDLE && accept && s_sof)) begin
        state <= S_PRIME;
        x     <= XW'(1);
        y     <= '0;
      end else begin
        case (state)
          S_IDLE: ;
          S_PRIME: begin
            if (accept) begin
              if (x == X_LAST) begin
                state <= S_RUN;
                x     <= '0;
                y     <= YW'(1);
              end else begin
                x <= x + XW'(1);
              end
            end
          end
          S_RUN: begin
            if (accept) begin
              tp2 <= tp1; tp1 <= lb0[x];
              mp2 <= mp1; mp1 <= lb1[x];
              bp2 <= bp1; bp1 <= s_data;
              if (x == X_LAST) begin
                state <= S_EOL;
              end else begin
                x <= x + XW'(1);
              end
            end
          end
          S_EOL: begin
            if (can_load) begin
              x <= '0;
              if (y == Y_LAST) begin
                state <= S_FLUSH;
              end else begin
                y     <= y + YW'(1);
                state <= S_RUN;
              end
            end
          end
          S_FLUSH: begin
            if (can_load) begin
              if (x == X_LAST) begin
                state <= S_IDLE;
                x     <= '0;
                y     <= '0;
              end else begin
                x <= x + XW'(1);
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
